sound_scheduler: RTL and testbench

Arbitrates the four sound event sources (bad collision, good collision, button, direction) onto the single shared tone oscillator path. Latches single-cycle event pulses and grants the highest-priority pending event. Drives the selected frequency and playSound for a fixed per-event duration, then enforces a silent gap before the next tone. Sits between the posedge detector outputs and the oscillator/DAC chain, replacing direct combinational frequency selection.

---
 rtl/sound_scheduler_pkg.sv | 41 ++++
 rtl/sound_scheduler_prescaler.sv | 24 ++
 rtl/sound_scheduler.sv | 169 ++++++++++++++++
 tb/tb_sound_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_scheduler_pkg.sv
// Shared types and constants for the sound event scheduler: FSM states,
// source indices, direction indices and the oscillator frequency table.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // Bit positions in the pending vector and in grant
  localparam logic [1:0] SRC_BAD  = 2'd0;
  localparam logic [1:0] SRC_GOOD = 2'd1;
  localparam logic [1:0] SRC_BTN  = 2'd2;
  localparam logic [1:0] SRC_DIR  = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [8:0] FREQ_BAD   = 9'd100;
  localparam logic [8:0] FREQ_GOOD  = 9'd400;
  localparam logic [8:0] FREQ_BTN   = 9'd300;
  localparam logic [8:0] FREQ_UP    = 9'd262;
  localparam logic [8:0] FREQ_DOWN  = 9'd196;
  localparam logic [8:0] FREQ_LEFT  = 9'd220;
  localparam logic [8:0] FREQ_RIGHT = 9'd247;

  function automatic logic [8:0] dir_freq(input logic [1:0] dir_idx);
    logic [8:0] f;
    case (dir_idx)
      DIR_UP:    f = FREQ_UP;
      DIR_DOWN:  f = FREQ_DOWN;
      DIR_LEFT:  f = FREQ_LEFT;
      default:   f = FREQ_RIGHT;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sound_scheduler_prescaler.sv
// Free-running duration-tick prescaler: one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter logic [15:0] TICK_DIV = 16'd10000
) (
  input  logic clk,
  input  logic nRst,
  output logic tick
);

  logic [15:0] count_reg;

  assign tick = (count_reg == TICK_DIV - 16'd1);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates four sound event sources onto one tone path: latches event
// pulses, plays the highest-priority one for its duration, then a silent gap.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter logic [15:0]      TICK_DIV  = 16'd10000,
  parameter int               DUR_W     = 8,
  parameter logic [DUR_W-1:0] DUR_BAD   = 8'd40,
  parameter logic [DUR_W-1:0] DUR_GOOD  = 8'd20,
  parameter logic [DUR_W-1:0] DUR_BTN   = 8'd10,
  parameter logic [DUR_W-1:0] DUR_DIR   = 8'd5,
  parameter logic [DUR_W-1:0] GAP_TICKS = 8'd2
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic       button,
  input  logic [3:0] direction,
  output logic [8:0] freq,
  output logic       playSound,
  output logic [3:0] grant,
  output logic       busy
);

  localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

  function automatic logic [DUR_W-1:0] fix_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  sched_state_t     state_reg, state_next;
  logic [DUR_W-1:0] count_reg, count_next;
  logic [3:0]       grant_reg, grant_next;
  logic [8:0]       freq_reg, freq_next;
  logic [3:0]       pending_reg, pending_next;
  logic [1:0]       dir_reg, dir_next;
  logic [3:0]       set_mask, clr_mask;
  logic             dir_valid;
  logic [1:0]       dir_enc;
  logic [1:0]       winner;
  logic [8:0]       win_freq;
  logic [DUR_W-1:0] win_dur;
  logic             tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .nRst (nRst),
    .tick (tick)
  );

  // A direction pulse with zero or several bits set is not a request
  assign dir_valid = $onehot(direction);

  always_comb begin
    dir_enc = DIR_UP;
    if (direction[DIR_DOWN])       dir_enc = DIR_DOWN;
    else if (direction[DIR_LEFT])  dir_enc = DIR_LEFT;
    else if (direction[DIR_RIGHT]) dir_enc = DIR_RIGHT;
  end

  assign dir_next = dir_valid ? dir_enc : dir_reg;
  assign set_mask = {dir_valid, button, goodColl, badColl};

  // A new pulse wins over a clear of the same bit in the same cycle
  for (genvar gi = 0; gi < 4; gi++) begin : g_pending
    assign pending_next[gi] = set_mask[gi] | (pending_reg[gi] & ~clr_mask[gi]);
  end

  always_comb begin
    winner = SRC_DIR;
    if (pending_reg[SRC_BAD])       winner = SRC_BAD;
    else if (pending_reg[SRC_GOOD]) winner = SRC_GOOD;
    else if (pending_reg[SRC_BTN])  winner = SRC_BTN;
  end

  always_comb begin
    win_freq = dir_freq(dir_reg);
    win_dur  = fix_dur(DUR_DIR);
    case (winner)
      SRC_BAD:  begin win_freq = FREQ_BAD;  win_dur = fix_dur(DUR_BAD);  end
      SRC_GOOD: begin win_freq = FREQ_GOOD; win_dur = fix_dur(DUR_GOOD); end
      SRC_BTN:  begin win_freq = FREQ_BTN;  win_dur = fix_dur(DUR_BTN);  end
      default:  ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    grant_next = grant_reg;
    freq_next  = freq_reg;
    clr_mask   = '0;
    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) begin
          state_next = PLAY;
          grant_next = 4'b0001 << winner;
          clr_mask   = 4'b0001 << winner;
          freq_next  = win_freq;
          count_next = win_dur;
        end
      end
      PLAY: begin
        // Bad preempts anything else and beats expiry in the same cycle
        if (pending_reg[SRC_BAD] && !grant_reg[SRC_BAD]) begin
          grant_next = 4'b0001 << SRC_BAD;
          clr_mask   = 4'b0001 << SRC_BAD;
          freq_next  = FREQ_BAD;
          count_next = fix_dur(DUR_BAD);
        end else if (tick) begin
          if (count_reg == ONE) begin
            grant_next = '0;
            freq_next  = '0;
            if (GAP_TICKS != '0) begin
              state_next = GAP;
              count_next = GAP_TICKS;
            end else begin
              state_next = IDLE;
              count_next = '0;
            end
          end else begin
            count_next = count_reg - ONE;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (count_reg == ONE) begin
            state_next = IDLE;
            count_next = '0;
          end else begin
            count_next = count_reg - ONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        grant_next = '0;
        freq_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      grant_reg   <= '0;
      freq_reg    <= '0;
      pending_reg <= '0;
      dir_reg     <= DIR_UP;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      grant_reg   <= grant_next;
      freq_reg    <= freq_next;
      pending_reg <= pending_next;
      dir_reg     <= dir_next;
    end
  end

  assign freq      = freq_reg;
  assign grant     = grant_reg;
  assign playSound = (state_reg == PLAY);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench: stimulus queues expected tones, a negedge monitor checks
// each tone's grant/frequency/length and the following silent gap.
module tb_sound_scheduler;

  localparam int TDIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nRst, goodColl, badColl, button;
  logic [3:0] direction;
  logic [8:0] freq;
  logic       playSound, busy;
  logic [3:0] grant;

  logic       z_good, z_bad, z_button;
  logic [3:0] z_direction;
  logic [8:0] z_freq;
  logic       z_play, z_busy;
  logic [3:0] z_grant;

  sound_scheduler #(
    .TICK_DIV(16'd4), .DUR_W(8), .DUR_BAD(8'd6), .DUR_GOOD(8'd3),
    .DUR_BTN(8'd4), .DUR_DIR(8'd2), .GAP_TICKS(8'd2)
  ) dut (
    .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl),
    .button(button), .direction(direction), .freq(freq),
    .playSound(playSound), .grant(grant), .busy(busy)
  );

  sound_scheduler #(
    .TICK_DIV(16'd4), .DUR_W(8), .DUR_BAD(8'd6), .DUR_GOOD(8'd3),
    .DUR_BTN(8'd4), .DUR_DIR(8'd0), .GAP_TICKS(8'd0)
  ) dut_z (
    .clk(clk), .nRst(nRst), .goodColl(z_good), .badColl(z_bad),
    .button(z_button), .direction(z_direction), .freq(z_freq),
    .playSound(z_play), .grant(z_grant), .busy(z_busy)
  );

  typedef struct {
    logic [3:0] grant;
    logic [8:0] freq;
    int         ticks;   // 0: tone is expected to be preempted
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int actual, input int lo, input int hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
    end else begin
      $display("ok   %s: got %0d", name, actual);
    end
  endtask

  // Monitor state, one slot per instance
  logic       prev_play[2];
  logic [3:0] prev_grant[2];
  bit         have_cur[2];
  exp_t       cur[2];
  int         len[2];
  bit         in_gap[2];
  int         gap_len[2];

  task automatic mon_step(input int i, input logic play, input logic [3:0] g,
                          input logic [8:0] f, input logic b);
    bit   t_end, t_start;
    exp_t e;
    int   gexp;
    gexp    = (i == 0) ? 2 * TDIV : 0;
    t_end   = prev_play[i] && (!play || g != prev_grant[i]);
    t_start = play && (!prev_play[i] || g != prev_grant[i]);
    if (t_end && have_cur[i]) begin
      if (play) begin
        check($sformatf("inst%0d preempted tone ticks", i), 0, cur[i].ticks, cur[i].ticks);
      end else begin
        check($sformatf("inst%0d tone length cycles", i), len[i],
              (cur[i].ticks - 1) * TDIV + 1, cur[i].ticks * TDIV);
        in_gap[i]  = 1'b1;
        gap_len[i] = 0;
      end
      have_cur[i] = 1'b0;
    end
    if (in_gap[i]) begin
      if (b && !play) begin
        gap_len[i]++;
      end else begin
        check($sformatf("inst%0d gap cycles", i), gap_len[i], gexp, gexp);
        in_gap[i] = 1'b0;
      end
    end
    if (t_start) begin
      if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
        vectors++;
        miscompares++;
        $display("FAIL inst%0d unexpected tone: grant=%b freq=%0d, required no tone", i, g, f);
      end else begin
        if (i == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
        check($sformatf("inst%0d tone grant", i), int'(g), int'(e.grant), int'(e.grant));
        check($sformatf("inst%0d tone freq", i), int'(f), int'(e.freq), int'(e.freq));
        cur[i]      = e;
        have_cur[i] = 1'b1;
        len[i]      = 1;
      end
    end else if (play) begin
      len[i]++;
    end
    prev_play[i]  = play;
    prev_grant[i] = g;
  endtask

  always @(negedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < 2; i++) begin
        prev_play[i]  = 1'b0;
        prev_grant[i] = '0;
        have_cur[i]   = 1'b0;
        in_gap[i]     = 1'b0;
      end
    end else begin
      mon_step(0, playSound, grant, freq, busy);
      mon_step(1, z_play, z_grant, z_freq, z_busy);
    end
  end

  task automatic pulse(input logic b, input logic g, input logic bt, input logic [3:0] d);
    @(posedge clk); #1;
    badColl = b; goodColl = g; button = bt; direction = d;
    @(posedge clk); #1;
    badColl = 1'b0; goodColl = 1'b0; button = 1'b0; direction = 4'b0000;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy && !z_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle timeout: busy=%b z_busy=%b, required 0", busy, z_busy);
    end
  endtask

  task automatic wait_play();
    int n = 0;
    while (!playSound && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!playSound) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_play timeout: playSound=%b, required 1", playSound);
    end
  endtask

  task automatic busy_cycles(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
  endtask

  initial begin
    int nb;
    nRst = 1'b0; goodColl = 1'b0; badColl = 1'b0; button = 1'b0; direction = 4'b0000;
    z_good = 1'b0; z_bad = 1'b0; z_button = 1'b0; z_direction = 4'b0000;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;

    @(negedge clk);
    check("reset freq", int'(freq), 0, 0);
    check("reset playSound", int'(playSound), 0, 0);
    check("reset grant", int'(grant), 0, 0);
    check("reset busy", int'(busy), 0, 0);
    check("reset z busy", int'(z_busy), 0, 0);

    // Single good collision: exact two-edge latency, 3-tick tone, 2-tick gap
    exp0.push_back('{4'b0010, 9'd400, 3});
    pulse(1'b0, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    check("latency after capture edge", int'(playSound), 0, 0);
    @(negedge clk);
    check("latency after grant edge", int'(playSound), 1, 1);
    wait_idle();

    // Button and left together: button first, then dir after the gap
    exp0.push_back('{4'b0100, 9'd300, 4});
    exp0.push_back('{4'b1000, 9'd220, 2});
    pulse(1'b0, 1'b0, 1'b1, 4'b0100);
    wait_idle();

    // Bad preempts a running button tone; button is not replayed
    exp0.push_back('{4'b0100, 9'd300, 0});
    exp0.push_back('{4'b0001, 9'd100, 6});
    pulse(1'b0, 1'b0, 1'b1, 4'b0000);
    wait_play();
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, 4'b0000);
    wait_idle();

    // Multi-hot direction is ignored
    pulse(1'b0, 1'b0, 1'b0, 4'b0011);
    busy_cycles(12, nb);
    check("multi-hot direction busy cycles", nb, 0, 0);

    // Two directions while busy: one dir tone with the latest (up)
    exp0.push_back('{4'b0010, 9'd400, 3});
    exp0.push_back('{4'b1000, 9'd262, 2});
    pulse(1'b0, 1'b1, 1'b0, 4'b0000);
    wait_play();
    pulse(1'b0, 1'b0, 1'b0, 4'b1000);
    pulse(1'b0, 1'b0, 1'b0, 4'b0001);
    wait_idle();

    // Reset mid-tone with good pending: everything silent, nothing follows
    exp0.push_back('{4'b0010, 9'd400, 3});
    pulse(1'b0, 1'b1, 1'b0, 4'b0000);
    wait_play();
    pulse(1'b0, 1'b1, 1'b0, 4'b0000);
    @(posedge clk); #1 nRst = 1'b0;
    @(posedge clk); #1 nRst = 1'b1;
    @(negedge clk);
    check("post-reset freq", int'(freq), 0, 0);
    check("post-reset playSound", int'(playSound), 0, 0);
    check("post-reset grant", int'(grant), 0, 0);
    check("post-reset busy", int'(busy), 0, 0);
    busy_cycles(40, nb);
    check("post-reset busy cycles", nb, 0, 0);

    // Zero-duration dir, no gap: 1-tick tone, pending good starts right after
    exp1.push_back('{4'b1000, 9'd196, 1});
    exp1.push_back('{4'b0010, 9'd400, 3});
    @(posedge clk); #1 z_direction = 4'b0010;
    @(posedge clk); #1 z_direction = 4'b0000; z_good = 1'b1;
    @(posedge clk); #1 z_good = 1'b0;
    wait_idle();

    check("unconsumed expected tones inst0", exp0.size(), 0, 0);
    check("unconsumed expected tones inst1", exp1.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
